mod_n_cascade_counter: RTL and testbench

//  Cascade of STAGES mod-N counter stages with runtime-programmable modulus per stage,
//  up/down count, sync clear and parallel load. Stage 0 advances on en; stage k advances

---
 rtl/mod_n_cascade_counter_pkg.sv | 12 +
 rtl/mod_n_cascade_counter_stage.sv | 81 ++++++++
 rtl/mod_n_cascade_counter.sv | 80 ++++++++
 tb/tb_mod_n_cascade_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared constants and helpers for the mod-N cascade counter.
package mod_n_cascade_counter_pkg;

    localparam logic        DIR_UP  = 1'b1;
    localparam logic        DIR_DN  = 1'b0;
    localparam int unsigned MIN_MOD = 2;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_cascade_counter_stage.sv
// One mod-N counter stage: programmable modulus with a shadow, up/down count,
// combinational wrap output for same-cycle ripple into the next stage.
module mod_n_stage
    import mod_n_cascade_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEFAULT_MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_in,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap_comb,
    output logic             tick,
    output logic             load_clamp
);

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] W_DEF = WIDTH'(DEFAULT_MOD);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_mod_act;
    logic [WIDTH-1:0] r_mod_shd;
    logic             r_tick;

    logic [WIDTH-1:0] w_mod_new;
    logic [WIDTH-1:0] w_mod_new_m1;
    logic [WIDTH-1:0] w_next;
    logic             w_at_limit;
    logic             w_apply;

    always_comb begin
        // A write in this cycle bypasses the shadow so wrap/clr/load see it at once.
        w_mod_new    = mod_wr ? mod_val : r_mod_shd;
        w_mod_new_m1 = w_mod_new - W_ONE;
        w_at_limit   = (up_dn == DIR_UP) ? (r_count == (r_mod_act - W_ONE))
                                         : (r_count == '0);
        wrap_comb    = adv_in & ~clr & ~load & w_at_limit;
        load_clamp   = load & ~clr & (load_val >= w_mod_new);
        w_apply      = clr | load | wrap_comb;

        w_next = r_count;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            w_next = load_clamp ? w_mod_new_m1 : load_val;
        end else if (adv_in) begin
            if (up_dn == DIR_UP) begin
                w_next = w_at_limit ? '0 : (r_count + W_ONE);
            end else begin
                w_next = w_at_limit ? w_mod_new_m1 : (r_count - W_ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_mod_act <= W_DEF;
            r_mod_shd <= W_DEF;
            r_tick    <= 1'b0;
        end else begin
            r_count   <= w_next;
            r_tick    <= wrap_comb;
            r_mod_shd <= w_mod_new;
            if (w_apply) begin
                r_mod_act <= w_mod_new;
            end
        end
    end

    assign count = r_count;
    assign tick  = r_tick;

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Cascade of programmable mod-N stages with per-stage and whole-chain rollover pulses.
module mod_n_cascade_counter
    import mod_n_cascade_counter_pkg::*;
#(
    parameter  int unsigned STAGES      = 3,
    parameter  int unsigned WIDTH       = 4,
    parameter  int unsigned DEFAULT_MOD = 10,
    localparam int unsigned SEL_W       = sel_width(STAGES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [STAGES*WIDTH-1:0] load_val,
    input  logic                    mod_wr,
    input  logic [SEL_W-1:0]        mod_sel,
    input  logic [WIDTH-1:0]        mod_val,
    output logic [STAGES*WIDTH-1:0] count,
    output logic [STAGES-1:0]       tick,
    output logic                    all_tick,
    output logic                    mod_err
);

    logic              w_sel_ok;
    logic              w_val_ok;
    logic              w_reject;
    logic [STAGES-1:0] w_wr;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_wrap;
    logic [STAGES-1:0] w_clamp;
    logic [STAGES-1:0] w_tick;
    logic              r_mod_err;

    assign w_sel_ok = (32'(mod_sel) < STAGES);
    assign w_val_ok = (32'(mod_val) >= MIN_MOD);
    assign w_reject = mod_wr & ~(w_sel_ok & w_val_ok);
    assign w_adv[0] = en & ~clr & ~load;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign w_wr[k] = mod_wr & w_sel_ok & w_val_ok & (32'(mod_sel) == k);

        if (k > 0) begin : g_ripple
            assign w_adv[k] = w_wrap[k-1];
        end

        mod_n_stage #(
            .WIDTH       (WIDTH),
            .DEFAULT_MOD (DEFAULT_MOD)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv_in     (w_adv[k]),
            .up_dn      (up_dn),
            .clr        (clr),
            .load       (load),
            .load_val   (load_val[k*WIDTH +: WIDTH]),
            .mod_wr     (w_wr[k]),
            .mod_val    (mod_val),
            .count      (count[k*WIDTH +: WIDTH]),
            .wrap_comb  (w_wrap[k]),
            .tick       (w_tick[k]),
            .load_clamp (w_clamp[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mod_err <= 1'b0;
        end else begin
            r_mod_err <= w_reject | (|w_clamp);
        end
    end

    assign tick     = w_tick;
    assign all_tick = w_tick[STAGES-1];
    assign mod_err  = r_mod_err;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares after each edge.
module tb_mod_n_cascade_counter;

    localparam int NS = 3;
    localparam int W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, up_dn, clr, load, mod_wr;
    logic [NS*W-1:0]   load_val;
    logic [1:0]        mod_sel;
    logic [W-1:0]      mod_val;
    logic [NS*W-1:0]   count;
    logic [NS-1:0]     tick;
    logic              all_tick;
    logic              mod_err;

    mod_n_cascade_counter #(
        .STAGES      (NS),
        .WIDTH       (W),
        .DEFAULT_MOD (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_sel  (mod_sel),
        .mod_val  (mod_val),
        .count    (count),
        .tick     (tick),
        .all_tick (all_tick),
        .mod_err  (mod_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*W-1:0] cnt;
        logic [NS-1:0]   tk;
        logic            at;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_at  = 0;

    // Behavioural model: plain integer digits, active and pending modulus per stage.
    int m_cnt [NS];
    int m_act [NS];
    int m_shd [NS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_cnt[k] = 0;
            m_act[k] = 10;
            m_shd[k] = 10;
        end
    endtask

    // Called at a negedge: drive inputs, predict the post-edge outputs, wait one cycle.
    task automatic cycle(input bit e, input bit u, input bit c, input bit l,
                         input logic [NS*W-1:0] lv, input bit wr, input int sel, input int val);
        exp_t x;
        int   nm [NS];
        bit   bad, carry, wrapped;
        int   v;
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        mod_wr = wr; mod_sel = 2'(sel); mod_val = 4'(val);

        x.tk  = '0;
        x.err = 1'b0;
        bad   = wr && (val < 2 || sel >= NS);
        if (bad) x.err = 1'b1;
        for (int k = 0; k < NS; k++)
            nm[k] = (wr && !bad && sel == k) ? val : m_shd[k];

        if (c) begin
            for (int k = 0; k < NS; k++) begin
                m_cnt[k] = 0;
                m_act[k] = nm[k];
            end
        end else if (l) begin
            for (int k = 0; k < NS; k++) begin
                v = int'(lv[k*W +: W]);
                if (v >= nm[k]) begin
                    m_cnt[k] = nm[k] - 1;
                    x.err    = 1'b1;
                end else begin
                    m_cnt[k] = v;
                end
                m_act[k] = nm[k];
            end
        end else begin
            carry = e;
            for (int k = 0; k < NS; k++) begin
                wrapped = 1'b0;
                if (carry) begin
                    if (u) begin
                        wrapped  = (m_cnt[k] == m_act[k] - 1);
                        m_cnt[k] = wrapped ? 0 : m_cnt[k] + 1;
                    end else begin
                        wrapped  = (m_cnt[k] == 0);
                        m_cnt[k] = wrapped ? nm[k] - 1 : m_cnt[k] - 1;
                    end
                    if (wrapped) m_act[k] = nm[k];
                end
                x.tk[k] = wrapped;
                carry   = wrapped;
            end
        end
        for (int k = 0; k < NS; k++) begin
            m_shd[k]        = nm[k];
            x.cnt[k*W +: W] = 4'(m_cnt[k]);
        end
        x.at = x.tk[NS-1];
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(0, 1, 0, 0, '0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse entirely between edges; outputs must clear before the next edge.
    task automatic do_reset();
        en = 0; clr = 0; load = 0; mod_wr = 0;
        #2 rst = 1'b1;
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_all_tick", 32'(all_tick), 32'h0);
        chk("rst_mod_err", 32'(mod_err), 32'h0);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", 32'(count), 32'(e.cnt));
                chk("tick", 32'(tick), 32'(e.tk));
                chk("all_tick", 32'(all_tick), 32'(e.at));
                chk("mod_err", 32'(mod_err), 32'(e.err));
                if (all_tick) n_at++;
            end
        end
    end

    initial begin : driver
        rst = 1'b1; en = 0; up_dn = 1; clr = 0; load = 0; mod_wr = 0;
        load_val = '0; mod_sel = '0; mod_val = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("init_count", 32'(count), 32'h0);
        chk("init_tick", 32'(tick), 32'h0);

        // Full decimal sweep: 0x000..0x999 and back to 0x000 with exactly one chain rollover.
        n_at = 0;
        repeat (1000) cycle(1, 1, 0, 0, '0, 0, 0, 0);
        chk("sweep_all_tick_count", 32'(n_at), 32'd1);
        chk("sweep_end_count", 32'(count), 32'h000);

        // Down from zero: every stage wraps at once.
        do_reset();
        cycle(1, 0, 0, 0, '0, 0, 0, 0);
        chk("down_wrap_count", 32'(count), 32'h999);
        cycle(0, 0, 0, 0, '0, 0, 0, 0);

        // Deferred modulus change applied at the next wrap of stage 0.
        do_reset();
        repeat (3) cycle(1, 1, 0, 0, '0, 0, 0, 0);
        cycle(0, 1, 0, 0, '0, 1, 0, 6);
        repeat (20) cycle(1, 1, 0, 0, '0, 0, 0, 0);

        // Write coincident with wrap takes effect on that edge.
        do_reset();
        repeat (9) cycle(1, 1, 0, 0, '0, 0, 0, 0);
        cycle(1, 1, 0, 0, '0, 1, 0, 6);
        repeat (7) cycle(1, 1, 0, 0, '0, 0, 0, 0);

        // Rejected writes.
        cycle(0, 1, 0, 0, '0, 1, 0, 1);
        cycle(0, 1, 0, 0, '0, 1, 3, 7);
        repeat (12) cycle(1, 1, 0, 0, '0, 0, 0, 0);

        // Load with clamp, then clr+load+en together.
        do_reset();
        cycle(0, 1, 0, 1, 12'h7C2, 0, 0, 0);
        chk("load_clamp_count", 32'(count), 32'h792);
        cycle(1, 1, 1, 1, 12'h345, 1, 1, 4);
        repeat (10) cycle(1, 1, 0, 0, '0, 0, 0, 0);

        // Moduli pending/active restored by a mid-count reset.
        cycle(0, 1, 0, 0, '0, 1, 1, 5);
        cycle(0, 1, 0, 0, '0, 1, 0, 3);
        repeat (7) cycle(1, 1, 0, 0, '0, 0, 0, 0);
        do_reset();
        repeat (25) cycle(1, 1, 0, 0, '0, 0, 0, 0);

        // Down-wrap into a freshly written modulus.
        do_reset();
        cycle(0, 0, 0, 0, '0, 1, 0, 6);
        cycle(1, 0, 0, 0, '0, 0, 0, 0);
        chk("down_new_mod_digit0", 32'(count[3:0]), 32'h5);
        do_reset();
        cycle(1, 0, 0, 0, '0, 1, 0, 6);
        chk("down_bypass_digit0", 32'(count[3:0]), 32'h5);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 7) != 0,
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 32) == 0),
                  12'($urandom), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        idle_cycle();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
